// File: rtl/mux_arb_pipe.sv
// N:1 beat selector with per-input valid/ready, fixed-select or round-robin
// grant, and a 2-entry registered output buffer. The input side is ready only
// from registered occupancy, so out_ready never reaches in_ready combinationally.
module mux_arb_pipe #(
    parameter int NUM_IN   = 16,
    parameter int DATA_W   = 128,
    parameter int SEL_W    = $clog2(NUM_IN),
    parameter int ARB_MODE = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_IN-1:0]              in_valid,
    input  logic [NUM_IN-1:0][DATA_W-1:0]  in_data,
    output logic [NUM_IN-1:0]              in_ready,
    input  logic [SEL_W-1:0]               sel,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic [SEL_W-1:0]               out_src,
    input  logic                           out_ready,
    output logic                           sel_err
);

    logic [1:0]        count;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] tail_data;
    logic [SEL_W-1:0]  head_src;
    logic [SEL_W-1:0]  tail_src;
    logic [SEL_W-1:0]  rr_ptr;

    logic              space;
    logic              sel_ok;
    logic              gnt_found;
    logic [SEL_W-1:0]  gnt_idx;
    logic [NUM_IN-1:0] gnt;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;

    // Gating with rst_n keeps in_ready/sel_err low for the whole reset window.
    assign space  = rst_n && (count != 2'd2);
    assign sel_ok = {1'b0, sel} < (SEL_W+1)'(NUM_IN);

    // Grant selection: fixed index from sel, or first valid at/after rr_ptr.
    always_comb begin
        int cand_i;
        logic [SEL_W-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_i    = 0;
        cand      = '0;
        if (ARB_MODE == 0) begin
            gnt_found = sel_ok;
            gnt_idx   = sel;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                cand_i = int'(rr_ptr) + k;
                if (cand_i >= NUM_IN) begin
                    cand_i = cand_i - NUM_IN;
                end
                cand = SEL_W'(cand_i);
                if (!gnt_found && in_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    // One-hot ready toward the granted channel only when the buffer has room.
    always_comb begin
        gnt = '0;
        if (gnt_found && space) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign in_ready  = gnt;
    assign push      = |(in_valid & gnt);
    assign push_data = in_data[gnt_idx];
    assign pop       = out_valid && out_ready;
    assign sel_err   = (ARB_MODE == 0) && !sel_ok && space;

    assign out_valid = (count != 2'd0);
    assign out_data  = head_data;
    assign out_src   = head_src;

    // Two-entry buffer: head is always the oldest beat, tail the younger one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head_data <= '0;
            tail_data <= '0;
            head_src  <= '0;
            tail_src  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= push_data;
                        head_src  <= gnt_idx;
                    end else begin
                        tail_data <= push_data;
                        tail_src  <= gnt_idx;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_src  <= tail_src;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    // count is 1 here (push needs space, pop needs data) or 2 is excluded
                    if (count == 2'd1) begin
                        head_data <= push_data;
                        head_src  <= gnt_idx;
                    end else begin
                        head_data <= tail_data;
                        head_src  <= tail_src;
                        tail_data <= push_data;
                        tail_src  <= gnt_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-robin pointer moves just past the channel that completed a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if ((ARB_MODE != 0) && push) begin
            if (gnt_idx == SEL_W'(NUM_IN - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt_idx + 1'b1;
            end
        end
    end

endmodule
